discrete_mixer: RTL and testbench

Time-multiplexed weighted mixer that sits directly downstream of the per-sound discrete circuit models (walk, jump, stomp, …). On every audio sample strobe it snapshots all channel samples and their gains, then walks one multiply-accumulate per clock, and emits one saturated signed 16-bit sample with a one-cycle valid pulse. Its output feeds the board-level output filter and the DAC path.

---
 rtl/discrete_pkg.sv | 19 +
 rtl/signed_saturate.sv | 24 ++
 rtl/discrete_mixer.sv | 111 +++++++++++
 tb/tb_discrete_mixer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/discrete_pkg.sv
// Shared constants and types for the discrete sound-circuit output path.
// Sample/gain formats and the mixer state encoding live here so every stage agrees.
package discrete_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int GAIN_W     = 8;
  localparam int GAIN_FRAC  = 7;
  localparam int GAIN_UNITY = 128;

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } MixState;

endpackage

// File: rtl/signed_saturate.sv
// Clamps a wide signed value into the signed 16-bit audio sample range.
// Shared by the mixer and other output stages that widen before narrowing.
module signed_saturate
  import discrete_pkg::*;
#(
  parameter int IN_W = 26
) (
  input  logic signed [IN_W-1:0]     i_value,
  output logic signed [SAMPLE_W-1:0] o_value
);

  localparam logic signed [IN_W-1:0] MAX_EXT = IN_W'(SAMPLE_MAX);
  localparam logic signed [IN_W-1:0] MIN_EXT = IN_W'(SAMPLE_MIN);

  always_comb begin
    o_value = i_value[SAMPLE_W-1:0];
    if (i_value > MAX_EXT) begin
      o_value = SAMPLE_MAX;
    end else if (i_value < MIN_EXT) begin
      o_value = SAMPLE_MIN;
    end
  end

endmodule

// File: rtl/discrete_mixer.sv
// Time-multiplexed weighted mixer: snapshots all channels on the audio strobe,
// then does one signed MAC per clock and emits a saturated 16-bit sample.
module discrete_mixer
  import discrete_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CLOCK_RATE   = 1000000,
  parameter int SAMPLE_RATE  = 96000
) (
  input  logic                                clk,
  input  logic                                I_RST,
  input  logic                                audio_clk_en,
  input  logic [SAMPLE_W*NUM_CHANNELS-1:0]    in,
  input  logic [GAIN_W*NUM_CHANNELS-1:0]      gain,
  output logic signed [SAMPLE_W-1:0]          out,
  output logic                                out_valid,
  output logic                                busy,
  output logic                                overrun
);

  localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(NUM_CHANNELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  // A mix must finish (N MACs plus the DONE cycle) before the next strobe can land.
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16 ||
      (CLOCK_RATE / SAMPLE_RATE) < (NUM_CHANNELS + 2)) begin : g_badConfig
    $error("discrete_mixer: unsupported channel count or clock/sample ratio");
  end

  MixState                    r_state;
  MixState                    w_nextState;
  logic [IDX_W-1:0]           r_idx;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [SAMPLE_W-1:0] r_snapIn   [NUM_CHANNELS];
  logic [GAIN_W-1:0]          r_snapGain [NUM_CHANNELS];
  logic signed [SAMPLE_W-1:0] r_out;
  logic                       r_outValid;
  logic                       r_overrun;

  logic signed [SAMPLE_W-1:0] w_curIn;
  logic [GAIN_W-1:0]          w_curGain;
  logic signed [PROD_W-1:0]   w_product;
  logic signed [ACC_W-1:0]    w_shifted;
  logic signed [SAMPLE_W-1:0] w_sat;
  logic                       w_capture;

  assign w_curIn   = r_snapIn[r_idx];
  assign w_curGain = r_snapGain[r_idx];
  // Gain is unsigned, so widen it with a zero sign bit before the signed multiply.
  assign w_product = w_curIn * $signed({1'b0, w_curGain});
  assign w_shifted = r_acc >>> GAIN_FRAC;
  assign w_capture = audio_clk_en && (r_state == IDLE || r_state == DONE);

  signed_saturate #(.IN_W(ACC_W)) u_saturate (
    .i_value (w_shifted),
    .o_value (w_sat)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (audio_clk_en) w_nextState = ACCUM;
      ACCUM:   if (r_idx == LAST_IDX) w_nextState = DONE;
      DONE:    w_nextState = audio_clk_en ? ACCUM : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_acc      <= '0;
      r_out      <= '0;
      r_outValid <= 1'b0;
      r_overrun  <= 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        r_snapIn[k]   <= '0;
        r_snapGain[k] <= '0;
      end
    end else begin
      r_state    <= w_nextState;
      r_outValid <= (r_state == DONE);
      if (r_state == ACCUM && audio_clk_en) begin
        r_overrun <= 1'b1;
      end
      if (r_state == DONE) begin
        r_out <= w_sat;
      end
      if (w_capture) begin
        r_acc <= '0;
        r_idx <= '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          r_snapIn[k]   <= in[k*SAMPLE_W +: SAMPLE_W];
          r_snapGain[k] <= gain[k*GAIN_W +: GAIN_W];
        end
      end else if (r_state == ACCUM) begin
        r_acc <= r_acc + ACC_W'(w_product);
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_outValid;
  assign busy      = (r_state != IDLE);
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_discrete_mixer.sv
// Directed bench for discrete_mixer (4 channels) with hand-computed mixes.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_discrete_mixer;

  logic               clk = 1'b0;
  logic               I_RST;
  logic               audio_clk_en;
  logic [63:0]        inBus;
  logic [31:0]        gainBus;
  logic signed [15:0] outSample;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  int vectors     = 0;
  int miscompares = 0;

  discrete_mixer #(
    .NUM_CHANNELS (4),
    .CLOCK_RATE   (1000000),
    .SAMPLE_RATE  (96000)
  ) dut (
    .clk          (clk),
    .I_RST        (I_RST),
    .audio_clk_en (audio_clk_en),
    .in           (inBus),
    .gain         (gainBus),
    .out          (outSample),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setChannels(input logic signed [15:0] s0, s1, s2, s3,
                             input logic [7:0] g0, g1, g2, g3);
    inBus   = {s3, s2, s1, s0};
    gainBus = {g3, g2, g1, g0};
  endtask

  // Strobe one mix and wait (bounded) for its out_valid; latency counts edges after the capture edge.
  task automatic applyStimulus(output logic found, output int latency,
                               output logic signed [15:0] value);
    audio_clk_en = 1'b1;
    step();
    audio_clk_en = 1'b0;
    found   = 1'b0;
    latency = 0;
    value   = '0;
    for (int t = 0; t < 20 && !found; t++) begin
      if (out_valid === 1'b1) begin
        found   = 1'b1;
        latency = t;
        value   = outSample;
      end else begin
        step();
      end
    end
  endtask

  task automatic test_reset();
    I_RST        = 1'b1;
    audio_clk_en = 1'b0;
    setChannels(16'sd0, 16'sd0, 16'sd0, 16'sd0, 8'd0, 8'd0, 8'd0, 8'd0);
    step();
    step();
    vectors++; if (outSample !== 16'sd0) begin miscompares++; $display("[TB] FAIL reset_out: got %0d, expected 0", outSample); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b, expected 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overrun: got %b, expected 0", overrun); end
    I_RST = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic expBusy, expValid;
    setChannels(16'sd1000, 16'sd0, 16'sd0, 16'sd0, 8'd128, 8'd0, 8'd0, 8'd0);
    audio_clk_en = 1'b1;
    step();
    audio_clk_en = 1'b0;
    for (int t = 0; t <= 6; t++) begin
      expBusy  = (t <= 4);
      expValid = (t == 5);
      vectors++; if (busy !== expBusy) begin miscompares++; $display("[TB] FAIL basic_busy_t%0d: got %b, expected %b", t, busy, expBusy); end
      vectors++; if (out_valid !== expValid) begin miscompares++; $display("[TB] FAIL basic_valid_t%0d: got %b, expected %b", t, out_valid, expValid); end
      if (t >= 5) begin
        vectors++; if (outSample !== 16'sd1000) begin miscompares++; $display("[TB] FAIL basic_out_t%0d: got %0d, expected 1000", t, outSample); end
      end
      if (t < 6) step();
    end
  endtask

  task automatic test_multichannel();
    logic found; int latency; logic signed [15:0] value;
    // 1000*128 - 500*64 + 300*255 - 7*1 = 172493; floor(172493/128) = 1347
    setChannels(16'sd1000, -16'sd500, 16'sd300, -16'sd7, 8'd128, 8'd64, 8'd255, 8'd1);
    applyStimulus(found, latency, value);
    vectors++; if (found !== 1'b1 || latency != 5) begin miscompares++; $display("[TB] FAIL multi_timing: got found=%b latency=%0d, expected found=1 latency=5", found, latency); end
    vectors++; if (value !== 16'sd1347) begin miscompares++; $display("[TB] FAIL multi_out: got %0d, expected 1347", value); end
  endtask

  task automatic test_saturation();
    logic signed [15:0] samp [2] = '{16'sd20000, -16'sd20000};
    logic signed [15:0] expv [2] = '{16'sd32767, -16'sd32768};
    logic found; int latency; logic signed [15:0] value;
    for (int i = 0; i < 2; i++) begin
      setChannels(samp[i], samp[i], 16'sd0, 16'sd0, 8'd128, 8'd128, 8'd0, 8'd0);
      applyStimulus(found, latency, value);
      vectors++; if (found !== 1'b1 || latency != 5) begin miscompares++; $display("[TB] FAIL sat%0d_timing: got found=%b latency=%0d, expected found=1 latency=5", i, found, latency); end
      vectors++; if (value !== expv[i]) begin miscompares++; $display("[TB] FAIL sat%0d_out: got %0d, expected %0d", i, value, expv[i]); end
    end
  endtask

  task automatic test_floor();
    logic signed [15:0] samp [3] = '{-16'sd3, 16'sd3, 16'sd100};
    logic [7:0]         gn   [3] = '{8'd64, 8'd64, 8'd255};
    logic signed [15:0] expv [3] = '{-16'sd2, 16'sd1, 16'sd199};
    logic found; int latency; logic signed [15:0] value;
    for (int i = 0; i < 3; i++) begin
      setChannels(samp[i], 16'sd0, 16'sd0, 16'sd0, gn[i], 8'd0, 8'd0, 8'd0);
      applyStimulus(found, latency, value);
      vectors++; if (found !== 1'b1 || value !== expv[i]) begin miscompares++; $display("[TB] FAIL floor%0d_out: got found=%b out=%0d, expected out=%0d", i, found, value, expv[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic expValid;
    setChannels(16'sd1000, 16'sd0, 16'sd0, 16'sd0, 8'd128, 8'd0, 8'd0, 8'd0);
    audio_clk_en = 1'b1;
    step();
    audio_clk_en = 1'b0;
    for (int t = 0; t <= 10; t++) begin
      expValid = (t == 5 || t == 10);
      vectors++; if (out_valid !== expValid) begin miscompares++; $display("[TB] FAIL b2b_valid_t%0d: got %b, expected %b", t, out_valid, expValid); end
      if (t == 5) begin
        vectors++; if (outSample !== 16'sd1000) begin miscompares++; $display("[TB] FAIL b2b_first_out: got %0d, expected 1000", outSample); end
        audio_clk_en = 1'b0;
      end
      if (t == 10) begin
        vectors++; if (outSample !== -16'sd1234) begin miscompares++; $display("[TB] FAIL b2b_second_out: got %0d, expected -1234", outSample); end
      end
      if (t == 4) begin
        setChannels(-16'sd1234, 16'sd0, 16'sd0, 16'sd0, 8'd128, 8'd0, 8'd0, 8'd0);
        audio_clk_en = 1'b1;
      end
      if (t < 10) step();
    end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_overrun: got %b, expected 0", overrun); end
  endtask

  task automatic test_overrun();
    logic expValid;
    setChannels(16'sd0, 16'sd500, 16'sd0, 16'sd0, 8'd0, 8'd128, 8'd0, 8'd0);
    audio_clk_en = 1'b1;
    step();
    audio_clk_en = 1'b0;
    for (int t = 0; t <= 8; t++) begin
      expValid = (t == 5);
      vectors++; if (out_valid !== expValid) begin miscompares++; $display("[TB] FAIL ovr_valid_t%0d: got %b, expected %b", t, out_valid, expValid); end
      if (t == 1) begin
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_early: got %b, expected 0", overrun); end
        setChannels(16'sd0, 16'sd9999, 16'sd0, 16'sd0, 8'd0, 8'd128, 8'd0, 8'd0);
        audio_clk_en = 1'b1;
      end
      if (t == 2) audio_clk_en = 1'b0;
      if (t == 5) begin
        vectors++; if (outSample !== 16'sd500) begin miscompares++; $display("[TB] FAIL ovr_out: got %0d, expected 500", outSample); end
      end
      if (t == 6) begin
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_busy: got %b, expected 0", busy); end
      end
      if (t < 8) step();
    end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_sticky: got %b, expected 1", overrun); end
  endtask

  task automatic test_input_hold();
    logic found; int latency; logic signed [15:0] value;
    // 4000*32 = 128000; >>>7 = 1000
    setChannels(16'sd0, 16'sd0, 16'sd4000, 16'sd0, 8'd0, 8'd0, 8'd32, 8'd0);
    audio_clk_en = 1'b1;
    step();
    audio_clk_en = 1'b0;
    step();
    setChannels(16'sd5000, 16'sd0, -16'sd4000, 16'sd0, 8'd128, 8'd0, 8'd255, 8'd0);
    found = 1'b0;
    latency = 1;
    value = '0;
    for (int t = 1; t < 20 && !found; t++) begin
      if (out_valid === 1'b1) begin
        found = 1'b1; latency = t; value = outSample;
      end else begin
        step();
      end
    end
    vectors++; if (found !== 1'b1 || latency != 5) begin miscompares++; $display("[TB] FAIL hold_timing: got found=%b latency=%0d, expected found=1 latency=5", found, latency); end
    vectors++; if (value !== 16'sd1000) begin miscompares++; $display("[TB] FAIL hold_out: got %0d, expected 1000", value); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    logic found; int latency; logic signed [15:0] value;
    setChannels(16'sd777, 16'sd0, 16'sd0, 16'sd0, 8'd128, 8'd0, 8'd0, 8'd0);
    audio_clk_en = 1'b1;
    step();
    audio_clk_en = 1'b0;
    step();
    I_RST = 1'b1;
    #1;
    vectors++; if (outSample !== 16'sd0) begin miscompares++; $display("[TB] FAIL rstmid_out: got %0d, expected 0", outSample); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_busy: got %b, expected 0", busy); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_overrun: got %b, expected 0", overrun); end
    step();
    I_RST = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (out_valid === 1'b1) pulses++;
      step();
    end
    vectors++; if (pulses != 0) begin miscompares++; $display("[TB] FAIL rstmid_pulses: got %0d, expected 0", pulses); end
    setChannels(16'sd42, 16'sd0, 16'sd0, 16'sd0, 8'd128, 8'd0, 8'd0, 8'd0);
    applyStimulus(found, latency, value);
    vectors++; if (found !== 1'b1 || latency != 5) begin miscompares++; $display("[TB] FAIL rstmid_next_timing: got found=%b latency=%0d, expected found=1 latency=5", found, latency); end
    vectors++; if (value !== 16'sd42) begin miscompares++; $display("[TB] FAIL rstmid_next_out: got %0d, expected 42", value); end
  endtask

  initial begin
    I_RST        = 1'b1;
    audio_clk_en = 1'b0;
    inBus        = '0;
    gainBus      = '0;
    #2;
    test_reset();
    test_basic();
    test_multichannel();
    test_saturation();
    test_floor();
    test_back_to_back();
    test_overrun();
    test_input_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
